// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment read-back path: segment codes
// (active-high, bit0=a .. bit6=g) and the converter state encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational decode of one seven-segment pattern back to its decimal digit.
// A blank pattern reads as 0; anything outside the code table is flagged.
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] digit_o,
    output logic       invalid_o
);

    always_comb begin
        digit_o   = 4'd0;
        invalid_o = 1'b0;
        case (seg_i)
            SEG_BLANK: digit_o = 4'd0;
            SEG_0:     digit_o = 4'd0;
            SEG_1:     digit_o = 4'd1;
            SEG_2:     digit_o = 4'd2;
            SEG_3:     digit_o = 4'd3;
            SEG_4:     digit_o = 4'd4;
            SEG_5:     digit_o = 4'd5;
            SEG_6:     digit_o = 4'd6;
            SEG_7:     digit_o = 4'd7;
            SEG_8:     digit_o = 4'd8;
            SEG_9:     digit_o = 4'd9;
            default:   invalid_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_to_binary.sv
// Converts NUM_DIGITS latched seven-segment patterns (most significant first)
// into a binary value, one digit per clock, with valid/ready on both sides.
module seg7_to_binary
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int OUT_W      = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7*NUM_DIGITS-1:0] segs,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        bin_out,
    output logic                    err
);

    localparam int              IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    state_t                  state_q, state_d;
    logic [7*NUM_DIGITS-1:0] segs_q,  segs_d;
    logic [OUT_W-1:0]        acc_q,   acc_d;
    logic [IDX_W-1:0]        idx_q,   idx_d;
    logic                    err_q,   err_d;

    logic [6:0]              cur_seg;
    logic [3:0]              cur_digit;
    logic                    cur_invalid;

    // acc*10 + digit built from shifts; wraps modulo 2^OUT_W if OUT_W is undersized.
    function automatic logic [OUT_W-1:0] mac10(input logic [OUT_W-1:0] acc,
                                               input logic [3:0]       digit);
        return (acc << 3) + (acc << 1) + OUT_W'(digit);
    endfunction

    always_comb begin
        cur_seg = SEG_BLANK;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_seg = segs_q[7*i +: 7];
            end
        end
    end

    seg7_digit_decode u_decode (
        .seg_i     (cur_seg),
        .digit_o   (cur_digit),
        .invalid_o (cur_invalid)
    );

    always_comb begin
        state_d   = state_q;
        segs_d    = segs_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        err_d     = err_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        bin_out   = '0;
        err       = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    segs_d  = segs;
                    acc_d   = '0;
                    idx_d   = IDX_LAST;
                    err_d   = 1'b0;
                    state_d = CONV;
                end
            end

            CONV: begin
                acc_d = mac10(acc_q, cur_digit);
                err_d = err_q | cur_invalid;
                if (idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end

            DONE: begin
                out_valid = 1'b1;
                bin_out   = err_q ? '0 : acc_q;
                err       = err_q;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            segs_q  <= '0;
            acc_q   <= '0;
            idx_q   <= IDX_LAST;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            segs_q  <= segs_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_seg7_to_binary.sv
// Randomized and directed bench for seg7_to_binary against a table-lookup
// reference that sums digit * 10^position.
module tb_seg7_to_binary;

    localparam int N = 2;
    localparam int W = 7;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [7*N-1:0] segs;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   bin_out;
    logic           err;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int last_acc = -100;

    logic [6:0] seg_tab [10];

    seg7_to_binary #(.NUM_DIGITS(N), .OUT_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .segs      (segs),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int seg_digit(input logic [6:0] c);
        int d;
        d = -1;
        if (c == 7'h00) d = 0;
        for (int k = 0; k < 10; k++) begin
            if (seg_tab[k] == c) d = k;
        end
        return d;
    endfunction

    task automatic model(input logic [7*N-1:0] s, output int eb, output int ee);
        int v;
        int p;
        v  = 0;
        p  = 1;
        ee = 0;
        for (int i = 0; i < N; i++) begin
            int d;
            d = seg_digit(s[7*i +: 7]);
            if (d < 0) ee = 1;
            else v += d * p;
            p *= 10;
        end
        eb = ee ? 0 : (v % (1 << W));
    endtask

    task automatic run_word(input logic [7*N-1:0] s, input int hold, input int eb,
                            input int ee, input bit b2b, input string tag);
        int n;
        check_val({tag, "_rdy_idle"}, 32'(in_ready), 32'd1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        segs      = s;
        @(posedge clk);
        #1;
        if (b2b) check_val({tag, "_spacing"}, 32'(cyc - last_acc), 32'(N + 2));
        last_acc = cyc;
        in_valid = 1'b0;
        segs     = 14'($urandom);
        check_val({tag, "_rdy_conv"}, 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val({tag, "_lat"}, 32'(n), 32'(N));
        check_val({tag, "_bin"}, 32'(bin_out), 32'(eb));
        check_val({tag, "_err"}, 32'(err), 32'(ee));
        check_val({tag, "_rdy_done"}, 32'(in_ready), 32'd0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check_val({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
            check_val({tag, "_hold_bin"}, 32'(bin_out), 32'(eb));
            check_val({tag, "_hold_err"}, 32'(err), 32'(ee));
            check_val({tag, "_hold_rdy"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
        check_val({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7*N-1:0] s;
        int eb;
        int ee;

        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        segs      = '0;
        #12;
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_bin", 32'(bin_out), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_word({seg_tab[1], seg_tab[2]}, 0, 12, 0, 1'b0, "w12");

        run_word({seg_tab[6], seg_tab[7]}, 0, 67, 0, 1'b0, "b2b67");
        run_word({seg_tab[2], seg_tab[7]}, 0, 27, 0, 1'b1, "b2b27");
        run_word({seg_tab[9], seg_tab[9]}, 0, 99, 0, 1'b1, "b2b99");

        run_word({7'h00, seg_tab[5]}, 0, 5, 0, 1'b0, "blank5");
        run_word({7'h00, 7'h00}, 0, 0, 0, 1'b0, "blank0");
        run_word({seg_tab[3], 7'b1010101}, 0, 0, 1, 1'b0, "illegal");
        run_word({seg_tab[5], seg_tab[8]}, 5, 58, 0, 1'b0, "hold58");

        in_valid = 1'b1;
        segs     = {seg_tab[6], seg_tab[7]};
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("abort_vld", 32'(out_valid), 32'd0);
        check_val("abort_rdy", 32'(in_ready), 32'd1);
        check_val("abort_bin", 32'(bin_out), 32'd0);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check_val("abort_quiet", 32'(out_valid), 32'd0);
        end
        run_word({seg_tab[4], seg_tab[2]}, 0, 42, 0, 1'b0, "after_rst42");

        for (int w = 0; w < 40; w++) begin
            for (int i = 0; i < N; i++) begin
                int r;
                logic [6:0] c;
                r = $urandom_range(0, 11);
                if (r < 10) c = seg_tab[r];
                else if (r == 10) c = 7'h00;
                else begin
                    c = 7'($urandom);
                    for (int t = 0; t < 50 && seg_digit(c) >= 0; t++) c = 7'($urandom);
                    if (seg_digit(c) >= 0) c = 7'h55;
                end
                s[7*i +: 7] = c;
            end
            model(s, eb, ee);
            run_word(s, $urandom_range(0, 3), eb, ee, 1'b0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
